// File: rtl/gate_pkg.sv
// gate_pkg: shared state types and default timing for the gate motor path
package gate_pkg;
  localparam int DEF_DEAD_CYC = 4;
  localparam int DEF_TIMEOUT_CYC = 1000;
  typedef enum logic [4:0] {
    PARADO   = 5'b00001,
    ABRINDO  = 5'b00010,
    FECHANDO = 5'b00100,
    DEAD     = 5'b01000,
    FALHA    = 5'b10000
  } drv_state_t;
  typedef enum logic [2:0] {
    GS_FECHADO,
    GS_ABRINDO,
    GS_ABERTO,
    GS_FECHANDO,
    GS_PARADO
  } gate_state_t;
endpackage

// File: rtl/gate_cycle_counter.sv
// gate_cycle_counter: clearable up-counter that saturates at MAX
module gate_cycle_counter #(
  parameter int W = 4,
  parameter int MAX = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  // count cycles in the current state, holding at MAX
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (cnt != W'(MAX)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/gate_motor_driver.sv
// gate_motor_driver: motor enables with dead time, limit guards, timeout fault and obstacle stop
module gate_motor_driver
  import gate_pkg::*;
#(
  parameter int DEAD_CYC = DEF_DEAD_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic abrir_i,
  input  logic fechar_i,
  input  logic fca_i,
  input  logic fcc_i,
  input  logic obst_i,
  input  logic clr_falha_i,
  output logic mot_a_o,
  output logic mot_f_o,
  output logic falha_o,
  output logic obst_o
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DEAD_CYC - 1);
  drv_state_t cs, ns;
  logic [CNT_W-1:0] cnt;
  logic req_a, req_f, obst_hit;
  assign req_a = abrir_i & ~fechar_i & ~fca_i;
  assign req_f = fechar_i & ~abrir_i & ~fcc_i;
  gate_cycle_counter #(.W(CNT_W), .MAX(TIMEOUT_CYC)) u_cnt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr(ns != cs),
    .cnt(cnt)
  );
  // state register plus the obstacle pulse marking the first dead cycle
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      cs <= PARADO;
      obst_o <= 1'b0;
    end else begin
      cs <= ns;
      obst_o <= obst_hit;
    end
  // next state: stops and reversals always pass through DEAD
  always_comb begin
    ns = cs;
    obst_hit = 1'b0;
    case (cs)
      PARADO:   ns = req_a ? ABRINDO : req_f ? FECHANDO : PARADO;
      ABRINDO:  ns = (fca_i | ~abrir_i | fechar_i) ? DEAD : (cnt == T_LAST) ? FALHA : ABRINDO;
      FECHANDO: begin
        obst_hit = obst_i;
        ns = (obst_i | fcc_i | ~fechar_i | abrir_i) ? DEAD : (cnt == T_LAST) ? FALHA : FECHANDO;
      end
      DEAD:     ns = (cnt != D_LAST) ? DEAD : req_a ? ABRINDO : req_f ? FECHANDO : PARADO;
      FALHA:    ns = clr_falha_i ? DEAD : FALHA;
      default:  ns = PARADO;
    endcase
  end
  assign mot_a_o = cs == ABRINDO;
  assign mot_f_o = cs == FECHANDO;
  assign falha_o = cs == FALHA;
endmodule

// File: tb/tb_gate_motor_driver.sv
// tb_gate_motor_driver: directed vectors for the gate motor driver
module tb_gate_motor_driver;
  logic clk = 1'b0, rst = 1'b1;
  logic abrir = 0, fechar = 0, fca = 0, fcc = 0, obst = 0, clr_falha = 0;
  logic mot_a, mot_f, falha, obst_p;
  int errors = 0, checks = 0;
  gate_motor_driver #(.DEAD_CYC(4), .TIMEOUT_CYC(20)) dut (
    .clk_i(clk), .rst_i(rst), .abrir_i(abrir), .fechar_i(fechar),
    .fca_i(fca), .fcc_i(fcc), .obst_i(obst), .clr_falha_i(clr_falha),
    .mot_a_o(mot_a), .mot_f_o(mot_f), .falha_o(falha), .obst_o(obst_p)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (mot_a mot_f falha obst)", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  function automatic logic [3:0] outs();
    return {mot_a, mot_f, falha, obst_p};
  endfunction
  initial begin
    #1 check("reset", outs(), 4'b0000);
    step(1); rst = 0;
    step(1); abrir = 1;
    step(1); check("open_latency", outs(), 4'b1000);
    step(5); check("open_hold", outs(), 4'b1000);
    fca = 1;
    step(1); check("fca_stop", outs(), 4'b0000);
    for (int i = 0; i < 5; i++) begin step(1); check("fca_dead", outs(), 4'b0000); end
    abrir = 0; fca = 0;
    step(2); fechar = 1;
    step(1); check("close_start", outs(), 4'b0100);
    step(2); fechar = 0; abrir = 1;
    step(1); check("rev_dead0", outs(), 4'b0000);
    for (int i = 1; i < 4; i++) begin step(1); check("rev_dead", outs(), 4'b0000); end
    step(1); check("rev_open", outs(), 4'b1000);
    abrir = 0;
    step(6); fechar = 1;
    step(1); check("close_again", outs(), 4'b0100);
    obst = 1;
    step(1); check("obst_pulse", outs(), 4'b0001);
    obst = 0; fechar = 0;
    step(1); check("obst_low", outs(), 4'b0000);
    step(4); check("obst_parado", outs(), 4'b0000);
    obst = 1;
    step(2); check("obst_idle", outs(), 4'b0000);
    fechar = 1;
    step(1); check("close_fcc", outs(), 4'b0100);
    obst = 0; fcc = 1;
    step(1); check("fcc_stop", outs(), 4'b0000);
    fechar = 0; fcc = 0;
    step(6); abrir = 1; obst = 1;
    for (int i = 0; i < 20; i++) begin step(1); check("timeout_run", outs(), 4'b1000); end
    step(1); check("timeout_fault", outs(), 4'b0010);
    abrir = 0; obst = 0;
    step(2); check("fault_ignore", outs(), 4'b0010);
    abrir = 1;
    step(2); check("fault_hold", outs(), 4'b0010);
    clr_falha = 1;
    step(1); check("clr_dead0", outs(), 4'b0000);
    clr_falha = 0;
    for (int i = 1; i < 4; i++) begin step(1); check("clr_dead", outs(), 4'b0000); end
    step(1); check("clr_restart", outs(), 4'b1000);
    abrir = 0;
    step(6); abrir = 1; fechar = 1;
    step(3); check("both_req", outs(), 4'b0000);
    fechar = 0; fca = 1;
    step(3); check("fca_block", outs(), 4'b0000);
    abrir = 0; fechar = 1; fcc = 1;
    step(3); check("both_limits", outs(), 4'b0000);
    fechar = 0; fca = 0; fcc = 0; abrir = 1;
    step(1); check("pre_reset_run", outs(), 4'b1000);
    step(2);
    #2 rst = 1;
    #1 check("async_reset", outs(), 4'b0000);
    step(1); rst = 0;
    step(1); check("post_reset_run", outs(), 4'b1000);
    abrir = 0;
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
